// File: rtl/serial_in_fifo.sv
// serial_in_fifo: UART receiver + first-word-fall-through RX FIFO + hysteretic CTS.
// Sits between the rx pin and the downstream decoder, presenting received
// characters as a valid/ready stream and driving cts from real buffer occupancy.
//
// Ports:
//   clk                 in   system clock
//   reset               in   synchronous, active-high
//   rx                  in   asynchronous serial line, idle high
//   out_data            out  FIFO head, valid while out_data_available=1 (0 when empty)
//   out_data_available  out  FIFO not empty
//   receiver_ready      in   consumer takes the head this cycle
//   cts                 out  1 = sender must stop; set at level>=HIGH, cleared at level<=LOW
//   level               out  current FIFO occupancy
//   framing_error       out  1-cycle pulse: stop bit sampled 0
//   overflow            out  1-cycle pulse: complete character dropped, FIFO full
//   parity_error        out  1-cycle pulse: even-parity mismatch (SERIAL_IN_PARITY_EN only)
//
// Build option: define SERIAL_IN_PARITY_EN to add an even-parity bit after the
// data bits and the parity_error output.
module serial_in_fifo #(
  parameter int unsigned CLK_FREQUENCY_HZ   = 108_000_000,
  parameter int unsigned SERIAL_BPS         = 1_000_000,
  parameter int unsigned DATA_BITS          = 8,
  parameter int unsigned FIFO_DEPTH         = 16,
  parameter int unsigned CTS_HIGH_WATERMARK = 12,
  parameter int unsigned CTS_LOW_WATERMARK  = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               rx,
  output logic [DATA_BITS-1:0]               out_data,
  output logic                               out_data_available,
  input  logic                               receiver_ready,
  output logic                               cts,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    level,
  output logic                               framing_error,
  output logic                               overflow
`ifdef SERIAL_IN_PARITY_EN
  ,
  output logic                               parity_error
`endif
);

  localparam int unsigned BIT_TICKS  = (CLK_FREQUENCY_HZ + SERIAL_BPS / 2) / SERIAL_BPS;
  localparam int unsigned HALF_TICKS = BIT_TICKS / 2;
  localparam int unsigned CNT_W      = $clog2(BIT_TICKS + 1);
  localparam int unsigned BCNT_W     = $clog2(DATA_BITS + 1);
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(BIT_TICKS - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(HALF_TICKS - 1);
  localparam logic [BCNT_W-1:0] BITS_LAST = BCNT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef SERIAL_IN_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            sync_q;
  logic                  rx_s;
  logic [CNT_W-1:0]      tick_q, tick_d;
  logic [BCNT_W-1:0]     bitcnt_q, bitcnt_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  fe_q, fe_d;
  logic                  ovf_q, ovf_d;
  logic                  push;
`ifdef SERIAL_IN_PARITY_EN
  logic                  badpar_q, badpar_d;
  logic                  pe_q, pe_d;
`endif

  logic [DATA_BITS-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_q, rd_q;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  cts_q, cts_d;
  logic                  empty, full, pop, wr_en;

  assign rx_s = sync_q[1];

  // Receiver FSM: counts ticks from entry into each state and samples at the
  // last tick of the interval (half bit for START, full bit afterwards), so
  // every later sample lands mid-bit.
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q + 1'b1;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    fe_d     = 1'b0;
    push     = 1'b0;
`ifdef SERIAL_IN_PARITY_EN
    badpar_d = badpar_q;
    pe_d     = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        tick_d = '0;
        if (!rx_s) begin
          state_d  = S_START;
          bitcnt_d = '0;
`ifdef SERIAL_IN_PARITY_EN
          badpar_d = 1'b0;
`endif
        end
      end
      S_START: begin
        if (tick_q == HALF_LAST) begin
          tick_d  = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (tick_q == BIT_LAST) begin
          tick_d   = '0;
          shift_d  = {rx_s, shift_q[DATA_BITS-1:1]};
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == BITS_LAST) begin
`ifdef SERIAL_IN_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef SERIAL_IN_PARITY_EN
      S_PARITY: begin
        if (tick_q == BIT_LAST) begin
          tick_d  = '0;
          state_d = S_STOP;
          if ((^shift_q) != rx_s) begin
            badpar_d = 1'b1;
            pe_d     = 1'b1;
          end
        end
      end
`endif
      S_STOP: begin
        if (tick_q == BIT_LAST) begin
          tick_d = '0;
          if (rx_s) begin
            state_d = S_IDLE;
`ifdef SERIAL_IN_PARITY_EN
            push    = !badpar_q;
`else
            push    = 1'b1;
`endif
          end else begin
            state_d = S_WAIT_IDLE;
            fe_d    = 1'b1;
          end
        end
      end
      S_WAIT_IDLE: begin
        tick_d = '0;
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO control: a push into a full FIFO is accepted only when a pop frees
  // the slot in the same cycle.
  always_comb begin
    empty = (level_q == '0);
    full  = (level_q == LVL_W'(FIFO_DEPTH));
    pop   = !empty && receiver_ready;
    wr_en = push && (!full || pop);
    ovf_d = push && full && !pop;

    level_d = level_q;
    if (wr_en && !pop)      level_d = level_q + 1'b1;
    else if (!wr_en && pop) level_d = level_q - 1'b1;

    cts_d = cts_q;
    if (level_q >= LVL_W'(CTS_HIGH_WATERMARK))     cts_d = 1'b1;
    else if (level_q <= LVL_W'(CTS_LOW_WATERMARK)) cts_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= 2'b11;
      state_q  <= S_IDLE;
      tick_q   <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      fe_q     <= 1'b0;
      ovf_q    <= 1'b0;
      wr_q     <= '0;
      rd_q     <= '0;
      level_q  <= '0;
      cts_q    <= 1'b0;
`ifdef SERIAL_IN_PARITY_EN
      badpar_q <= 1'b0;
      pe_q     <= 1'b0;
`endif
    end else begin
      sync_q   <= {sync_q[0], rx};
      state_q  <= state_d;
      tick_q   <= tick_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      fe_q     <= fe_d;
      ovf_q    <= ovf_d;
      level_q  <= level_d;
      cts_q    <= cts_d;
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (pop)   rd_q <= rd_q + 1'b1;
`ifdef SERIAL_IN_PARITY_EN
      badpar_q <= badpar_d;
      pe_q     <= pe_d;
`endif
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= shift_q;
  end

  always_comb begin
    out_data           = empty ? '0 : mem_q[rd_q];
    out_data_available = !empty;
    level              = level_q;
    cts                = cts_q;
    framing_error      = fe_q;
    overflow           = ovf_q;
`ifdef SERIAL_IN_PARITY_EN
    parity_error       = pe_q;
`endif
  end

endmodule
